sysid_checker: RTL and testbench

SYSID_CHECKER -- requirements
Module: sysid_checker

---
 rtl/sysid_checker_pkg.sv | 24 ++
 rtl/sysid_checker_timeout.sv | 31 +++
 rtl/sysid_checker.sv | 150 +++++++++++++++
 tb/tb_sysid_checker.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sysid_checker_pkg.sv
// Shared types and constants for the system ID / timestamp checker.
package sysid_checker_pkg;

  // Width of the Avalon-MM read data and of the captured words.
  localparam int unsigned DataWidth = 32;

  // Width of the per-read timeout counter.
  localparam int unsigned CntWidth = 16;

  // Word addresses of the two registers read by the check.
  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  // Check sequence: one read phase and one wait-for-data phase per word.
  typedef enum logic [2:0] {
    StIdle,
    StRdId,
    StWtId,
    StRdTs,
    StWtTs,
    StFin
  } state_e;

endpackage

// File: rtl/sysid_checker_timeout.sv
// Per-read timeout counter. Cleared when a read phase is entered, counts every cycle a read is
// pending or awaiting data, and flags expiry on the cycle the count would reach Limit.
module sysid_checker_timeout
  import sysid_checker_pkg::*;
#(
  parameter int unsigned Limit = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [CntWidth-1:0] count_q;

  // Count cycles spent in the current read; restart from zero on each new read.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc) begin
      count_q <= count_q + CntWidth'(1);
    end
  end

  // Fires one cycle early so the abort edge coincides with the count reaching Limit.
  assign expired = inc && (count_q == CntWidth'(Limit - 1));

endmodule

// File: rtl/sysid_checker.sv
// System ID checker: after reset (and on each start pulse while idle) reads the ID word at
// address 0 and the timestamp word at address 1 over Avalon-MM, then reports whether both match
// the expected values. Optional per-read timeout is enabled by defining SYSID_CHECKER_TIMEOUT_EN.
module sysid_checker
  import sysid_checker_pkg::*;
#(
  parameter logic [DataWidth-1:0] EXPECTED_ID    = 32'd12345678,
  parameter logic [DataWidth-1:0] EXPECTED_TS    = 32'd1432136928,
  parameter int unsigned          TIMEOUT_CYCLES = 255
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  output logic                 avm_address,
  output logic                 avm_read,
  input  logic                 avm_waitrequest,
  input  logic                 avm_readdatavalid,
  input  logic [DataWidth-1:0] avm_readdata,
  output logic                 busy,
  output logic                 done,
  output logic                 id_ok,
  output logic                 ts_ok,
  output logic                 timeout,
  output logic [DataWidth-1:0] id_value,
  output logic [DataWidth-1:0] ts_value
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : gen_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

  state_e               state_q;
  logic                 auto_q;     // pending auto-run after reset release
  logic                 avm_read_q;
  logic                 avm_address_q;
  logic                 done_q;
  logic                 id_ok_q;
  logic                 ts_ok_q;
  logic                 timeout_q;
  logic [DataWidth-1:0] id_value_q;
  logic [DataWidth-1:0] ts_value_q;
  logic                 expired;

`ifdef SYSID_CHECKER_TIMEOUT_EN
  logic cnt_clr;
  logic cnt_inc;

  // Restart the counter on every transition into a read phase; count in all read/wait phases.
  always_comb begin
    cnt_inc = (state_q != StIdle) && (state_q != StFin);
    cnt_clr = ((state_q == StIdle) && (auto_q || start)) ||
              ((state_q == StWtId) && avm_readdatavalid);
  end

  sysid_checker_timeout #(
    .Limit(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .expired(expired)
  );
`else
  assign expired = 1'b0;
`endif

  // Check sequence FSM with registered bus and status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      auto_q        <= 1'b1;
      avm_read_q    <= 1'b0;
      avm_address_q <= ADDR_ID;
      done_q        <= 1'b0;
      id_ok_q       <= 1'b0;
      ts_ok_q       <= 1'b0;
      timeout_q     <= 1'b0;
      id_value_q    <= '0;
      ts_value_q    <= '0;
    end else if (expired) begin
      // Abort: ok flags stay cleared (they were cleared at launch and FIN masks them).
      avm_read_q <= 1'b0;
      timeout_q  <= 1'b1;
      done_q     <= 1'b1;
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      state_q    <= StFin;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (auto_q || start) begin
            auto_q        <= 1'b0;
            done_q        <= 1'b0;
            id_ok_q       <= 1'b0;
            ts_ok_q       <= 1'b0;
            timeout_q     <= 1'b0;
            avm_read_q    <= 1'b1;
            avm_address_q <= ADDR_ID;
            state_q       <= StRdId;
          end
        end
        StRdId: begin
          if (!avm_waitrequest) begin
            avm_read_q <= 1'b0;
            state_q    <= StWtId;
          end
        end
        StWtId: begin
          if (avm_readdatavalid) begin
            id_value_q    <= avm_readdata;
            avm_read_q    <= 1'b1;
            avm_address_q <= ADDR_TS;
            state_q       <= StRdTs;
          end
        end
        StRdTs: begin
          if (!avm_waitrequest) begin
            avm_read_q <= 1'b0;
            state_q    <= StWtTs;
          end
        end
        StWtTs: begin
          if (avm_readdatavalid) begin
            ts_value_q <= avm_readdata;
            state_q    <= StFin;
          end
        end
        StFin: begin
          done_q  <= 1'b1;
          id_ok_q <= !timeout_q && (id_value_q == EXPECTED_ID);
          ts_ok_q <= !timeout_q && (ts_value_q == EXPECTED_TS);
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy        = (state_q != StIdle);
  assign avm_read    = avm_read_q;
  assign avm_address = avm_address_q;
  assign done        = done_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout     = timeout_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench for sysid_checker with an Avalon-MM slave model and a done-event scoreboard.
module tb_sysid_checker;

  localparam logic [31:0] ExpId = 32'd12345678;
  localparam logic [31:0] ExpTs = 32'd1432136928;

  logic        clock;
  logic        reset;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic        avm_readdatavalid;
  logic [31:0] avm_readdata;
  logic        busy;
  logic        done;
  logic        id_ok;
  logic        ts_ok;
  logic        timeout;
  logic [31:0] id_value;
  logic [31:0] ts_value;

  sysid_checker #(
    .EXPECTED_ID   (ExpId),
    .EXPECTED_TS   (ExpTs),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdatavalid(avm_readdatavalid),
    .avm_readdata     (avm_readdata),
    .busy             (busy),
    .done             (done),
    .id_ok            (id_ok),
    .ts_ok            (ts_ok),
    .timeout          (timeout),
    .id_value         (id_value),
    .ts_value         (ts_value)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int unsigned cyc;
    logic [31:0] id_value;
    logic [31:0] ts_value;
    logic        id_ok;
    logic        ts_ok;
    logic        timeout;
  } exp_t;

  exp_t sb[$];

  // Slave model configuration and state.
  logic [31:0] slv_id   = ExpId;
  logic [31:0] slv_ts   = ExpTs;
  int          wait_cfg = 0;
  logic        drop_ts  = 1'b0;
  logic        stray    = 1'b0;
  int          n_reads  = 0;
  int          n_stalls = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push_exp(input int unsigned lat, input logic [31:0] idv, input logic [31:0] tsv,
                          input logic iok, input logic tok, input logic to);
    exp_t e;
    e.cyc      = cyc + lat;
    e.id_value = idv;
    e.ts_value = tsv;
    e.id_ok    = iok;
    e.ts_ok    = tok;
    e.timeout  = to;
    sb.push_back(e);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_avm_read"}, 32'(avm_read), 32'd0);
    check({pfx, "_avm_address"}, 32'(avm_address), 32'd0);
    check({pfx, "_busy"}, 32'(busy), 32'd0);
    check({pfx, "_done"}, 32'(done), 32'd0);
    check({pfx, "_id_ok"}, 32'(id_ok), 32'd0);
    check({pfx, "_ts_ok"}, 32'(ts_ok), 32'd0);
    check({pfx, "_timeout"}, 32'(timeout), 32'd0);
    check({pfx, "_id_value"}, id_value, 32'd0);
    check({pfx, "_ts_value"}, ts_value, 32'd0);
  endtask

  // Slave model plus scoreboard monitor: acceptance sampled at negedge, responses driven 1 after
  // posedge, done rising edges popped against the expected queue.
  initial begin
    logic acc_pending = 1'b0;
    logic acc_addr    = 1'b0;
    logic read_prev   = 1'b0;
    logic stall_prev  = 1'b0;
    logic addr_prev   = 1'b0;
    logic done_prev   = 1'b0;
    int   wait_left   = 0;
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = 32'h0;
    forever begin
      @(negedge clock);
      if (avm_read && !avm_waitrequest) begin
        acc_pending = 1'b1;
        acc_addr    = avm_address;
        n_reads++;
      end
      @(posedge clock);
      #1;
      if (stall_prev) begin
        n_stalls++;
        check("stall_read_held", 32'(avm_read), 32'd1);
        check("stall_addr_held", 32'(avm_address), 32'(addr_prev));
      end
      if (acc_pending && !(acc_addr && drop_ts)) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = acc_addr ? slv_ts : slv_id;
      end else if (stray) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = 32'hDEADBEEF;
        stray             = 1'b0;
      end else begin
        avm_readdatavalid = 1'b0;
        avm_readdata      = $urandom;
      end
      acc_pending = 1'b0;
      if (avm_read && !read_prev) wait_left = wait_cfg;
      if (avm_read && wait_left > 0) begin
        avm_waitrequest = 1'b1;
        wait_left--;
      end else begin
        avm_waitrequest = 1'b0;
      end
      stall_prev = avm_read && avm_waitrequest;
      addr_prev  = avm_address;
      read_prev  = avm_read;

      if (done && !done_prev) begin
        check("sb_item_present", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          check("done_cycle", cyc, e.cyc);
          check("id_value", id_value, e.id_value);
          check("ts_value", ts_value, e.ts_value);
          check("id_ok", 32'(id_ok), 32'(e.id_ok));
          check("ts_ok", 32'(ts_ok), 32'(e.ts_ok));
          check("timeout", 32'(timeout), 32'(e.timeout));
        end
      end
      done_prev = done;
    end
  end

  initial begin
    int reads_base;
    reset = 1'b1;
    start = 1'b0;
    tick(3);
    check_all_zero("rst");

    // Auto-run after reset release: two reads, done six cycles later.
    reads_base = n_reads;
    reset = 1'b0;
    push_exp(6, ExpId, ExpTs, 1'b1, 1'b1, 1'b0);
    tick(5);
    check("auto_done_not_early", 32'(done), 32'd0);
    tick(5);
    check("auto_read_count", 32'(n_reads - reads_base), 32'd2);
    check("auto_sb_drained", 32'(sb.size()), 32'd0);

    // Wrong ID word.
    slv_id = 32'h00BC614F;
    start = 1'b1;
    push_exp(6, 32'h00BC614F, ExpTs, 1'b0, 1'b1, 1'b0);
    tick(1);
    start = 1'b0;
    check("start_clears_done", 32'(done), 32'd0);
    check("start_sets_busy", 32'(busy), 32'd1);
    tick(9);
    check("badid_sb_drained", 32'(sb.size()), 32'd0);
    slv_id = ExpId;

    // Three waitrequest cycles on each read.
    wait_cfg = 3;
    n_stalls = 0;
    start = 1'b1;
    push_exp(12, ExpId, ExpTs, 1'b1, 1'b1, 1'b0);
    tick(1);
    start = 1'b0;
    tick(15);
    check("wait_stall_count", 32'(n_stalls), 32'd6);
    check("wait_sb_drained", 32'(sb.size()), 32'd0);
    wait_cfg = 0;

    // Start during WT_ID is ignored; a later start in IDLE runs a fresh sequence.
    start = 1'b1;
    push_exp(6, ExpId, ExpTs, 1'b1, 1'b1, 1'b0);
    tick(1);
    start = 1'b0;
    tick(1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(4);
    check("busy_start_ignored", 32'(busy), 32'd0);
    tick(3);
    check("busy_start_not_queued", 32'(busy), 32'd0);
    reads_base = n_reads;
    start = 1'b1;
    push_exp(6, ExpId, ExpTs, 1'b1, 1'b1, 1'b0);
    tick(1);
    start = 1'b0;
    check("restart_done_cleared", 32'(done), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    tick(8);
    check("restart_read_count", 32'(n_reads - reads_base), 32'd2);
    check("restart_sb_drained", 32'(sb.size()), 32'd0);

    // Timestamp read never returns data.
    drop_ts = 1'b1;
`ifdef SYSID_CHECKER_TIMEOUT_EN
    start = 1'b1;
    push_exp(11, ExpId, ExpTs, 1'b0, 1'b0, 1'b1);
    tick(1);
    start = 1'b0;
    tick(14);
    check("timeout_sb_drained", 32'(sb.size()), 32'd0);
    check("timeout_idle", 32'(busy), 32'd0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(4);
`else
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(40);
    check("hang_busy", 32'(busy), 32'd1);
    check("hang_no_done", 32'(done), 32'd0);
`endif

    // Reset while waiting for timestamp data, with a stray readdatavalid afterwards.
    check("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick(1);
    check_all_zero("midrst");
    drop_ts = 1'b0;
    stray   = 1'b1;
    tick(2);
    check("stray_id_value", id_value, 32'd0);
    check("stray_ts_value", ts_value, 32'd0);
    check("stray_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    push_exp(6, ExpId, ExpTs, 1'b1, 1'b1, 1'b0);
    tick(10);
    check("final_sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
